// File: rtl/regbank_dump_if.sv
// regbank_dump_if: handshake/bus bundle between the dump sequencer and its environment
interface regbank_dump_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int ADDR_BITS     = 32
);
  logic                     dump_req;
  logic                     pipe_idle;
  logic [ADDR_BITS-1:0]     pc_in;
  logic [DATA_WIDTH-1:0]    rb_data_in;
  logic                     tx_ready;
  logic                     stall_out;
  logic [REG_ADDR_BITS-1:0] rb_addr_out;
  logic [7:0]               tx_data_out;
  logic                     tx_valid;
  logic                     busy;
  logic                     done;
  modport master (
    input  dump_req, pipe_idle, pc_in, rb_data_in, tx_ready,
    output stall_out, rb_addr_out, tx_data_out, tx_valid, busy, done
  );
  modport slave (
    output dump_req, pipe_idle, pc_in, rb_data_in, tx_ready,
    input  stall_out, rb_addr_out, tx_data_out, tx_valid, busy, done
  );
endinterface

// File: rtl/regbank_dump_ctrl.sv
// regbank_dump_ctrl: stalls the pipeline and streams the register bank MSB-first as bytes; REGDUMP_PC_EN prepends the PC
module regbank_dump_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int NUM_REGS      = 32,
  parameter int ADDR_BITS     = 32
) (
  input logic clk,
  input logic rst,
  regbank_dump_if.master bus
);
  localparam int SW = DATA_WIDTH > ADDR_BITS ? DATA_WIDTH : ADDR_BITS;
  localparam int CW = $clog2(SW / 8) + 1;
  localparam logic [REG_ADDR_BITS-1:0] LAST = REG_ADDR_BITS'(NUM_REGS - 1);
  typedef enum logic [2:0] {IDLE, DRAIN, PC, LOAD, SEND, DONE} state_t;
  state_t state, state_n;
  logic stall, stall_n, busy, busy_n, done, done_n, tx_valid, tx_valid_n, pc_ph, pc_ph_n;
  logic [REG_ADDR_BITS-1:0] addr, addr_n;
  logic [7:0] tx_data, tx_data_n;
  logic [SW-1:0] sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic xfer;
  assign xfer = tx_valid & bus.tx_ready;
  assign bus.stall_out   = stall;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.tx_valid    = tx_valid;
  assign bus.tx_data_out = tx_data;
  assign bus.rb_addr_out = addr;
`ifndef REGDUMP_PC_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc_in;
`endif
  // Sequencer state and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      stall    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      addr     <= '0;
      sh       <= '0;
      cnt      <= '0;
      pc_ph    <= 1'b0;
    end else begin
      state    <= state_n;
      stall    <= stall_n;
      busy     <= busy_n;
      done     <= done_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
      addr     <= addr_n;
      sh       <= sh_n;
      cnt      <= cnt_n;
      pc_ph    <= pc_ph_n;
    end
  end
  // Next-state and next-output logic; the top of sh always holds the byte being presented
  always_comb begin
    state_n    = state;
    stall_n    = stall;
    busy_n     = busy;
    done_n     = 1'b0;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    addr_n     = addr;
    sh_n       = sh;
    cnt_n      = cnt;
    pc_ph_n    = pc_ph;
    case (state)
      IDLE: if (bus.dump_req) begin
        state_n = DRAIN;
        stall_n = 1'b1;
        busy_n  = 1'b1;
      end
      DRAIN: if (bus.pipe_idle) begin
        addr_n = '0;
`ifdef REGDUMP_PC_EN
        state_n = PC;
`else
        state_n = LOAD;
`endif
      end
`ifdef REGDUMP_PC_EN
      PC: begin
        sh_n       = SW'(bus.pc_in) << (SW - ADDR_BITS);
        tx_data_n  = bus.pc_in[ADDR_BITS-1 -: 8];
        cnt_n      = CW'(ADDR_BITS / 8 - 1);
        tx_valid_n = 1'b1;
        pc_ph_n    = 1'b1;
        state_n    = SEND;
      end
`endif
      LOAD: begin
        sh_n       = SW'(bus.rb_data_in) << (SW - DATA_WIDTH);
        tx_data_n  = bus.rb_data_in[DATA_WIDTH-1 -: 8];
        cnt_n      = CW'(DATA_WIDTH / 8 - 1);
        tx_valid_n = 1'b1;
        state_n    = SEND;
      end
      SEND: if (xfer) begin
        if (cnt != '0) begin
          sh_n      = sh << 8;
          tx_data_n = sh[SW-9 -: 8];
          cnt_n     = cnt - 1'b1;
        end else begin
          tx_valid_n = 1'b0;
          if (pc_ph) begin
            pc_ph_n = 1'b0;
            state_n = LOAD;
          end else if (addr == LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
            stall_n = 1'b0;
            busy_n  = 1'b0;
            addr_n  = '0;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = LOAD;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
